// File: rtl/multitap_line_buffer.sv
// multitap_line_buffer: NUM_TAPS_P vertically aligned taps per accepted sample.
// Tap k is the sample accepted k*L beats earlier, with L latched at the start of a fill.
// Optional macro MULTITAP_LINE_BUFFER_FLUSH_EN adds flush_i for frame-boundary restart.
module multitap_line_buffer #(
    parameter int WIDTH_P     = 8,
    parameter int MAX_DELAY_P = 640,
    parameter int NUM_TAPS_P  = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
`ifdef MULTITAP_LINE_BUFFER_FLUSH_EN
    input  logic                          flush_i,
`endif
    input  logic [$clog2(MAX_DELAY_P+1)-1:0] len_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [WIDTH_P-1:0]            data_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [NUM_TAPS_P*WIDTH_P-1:0] taps_o,
    output logic [NUM_TAPS_P-1:0]         tap_valid_o,
    output logic                          primed_o
);

    localparam int ROWS = NUM_TAPS_P - 1;
    localparam int LW   = $clog2(MAX_DELAY_P + 1);
    localparam int PW   = $clog2(MAX_DELAY_P);
    localparam int FW   = $clog2(ROWS * MAX_DELAY_P + 1);

    logic                          flush;
    logic                          accept;
    logic [PW-1:0]                 ptr;
    logic [PW-1:0]                 ptr_next;
    logic [FW-1:0]                 fill_cnt;
    logic [FW-1:0]                 fill_next;
    logic [FW-1:0]                 fill_max;
    logic [LW-1:0]                 len_q;
    logic [LW-1:0]                 len_clamped;
    logic [LW-1:0]                 len_eff;
    logic [WIDTH_P-1:0]            mem [ROWS][MAX_DELAY_P];
    logic [WIDTH_P-1:0]            tap_raw [NUM_TAPS_P];
    logic [NUM_TAPS_P-1:0]         tap_valid_next;
    logic [NUM_TAPS_P*WIDTH_P-1:0] taps_next;

`ifdef MULTITAP_LINE_BUFFER_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    // Single output register: a new beat is taken whenever that register is free or draining.
    assign ready_o = !flush && (!valid_o || ready_i);
    assign accept  = valid_i && ready_o;

    // Line length and fill bookkeeping; the first beat of a fill already uses the incoming length.
    always_comb begin
        len_clamped = (len_i == '0 || len_i > LW'(MAX_DELAY_P)) ? LW'(MAX_DELAY_P) : len_i;
        len_eff     = (fill_cnt == '0) ? len_clamped : len_q;
        ptr_next    = (LW'(ptr) == len_eff - LW'(1)) ? '0 : ptr + PW'(1);
        fill_max    = FW'(ROWS) * FW'(len_eff);
        fill_next   = (fill_cnt >= fill_max) ? fill_max : fill_cnt + FW'(1);
    end

    // Tap assembly: tap 0 is the live sample, tap r is the oldest entry of delay row r-1.
    always_comb begin
        tap_raw[0] = data_i;
        for (int r = 0; r < ROWS; r++) begin
            // NOTE: asynchronous read of the delay RAM keeps the whole path at one cycle of latency.
            tap_raw[r+1] = mem[r][ptr];
        end
        tap_valid_next = '0;
        taps_next      = '0;
        for (int k = 0; k < NUM_TAPS_P; k++) begin
            tap_valid_next[k] = fill_cnt >= FW'(k) * FW'(len_eff);
            taps_next[k*WIDTH_P +: WIDTH_P] = tap_valid_next[k] ? tap_raw[k] : '0;
        end
    end

    // Delay rows: each row hands its oldest sample to the next row at the same pointer slot.
    // NOTE: the RAM is deliberately never reset; stale entries are hidden by the tap-valid mask.
    always_ff @(posedge clk_i) begin
        if (!rst_i && accept) begin
            for (int r = 0; r < ROWS; r++) begin
                mem[r][ptr] <= tap_raw[r];
            end
        end
    end

    // Control state and the output register, including stall hold and restart.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o     <= 1'b0;
            taps_o      <= '0;
            tap_valid_o <= '0;
            primed_o    <= 1'b0;
            ptr         <= '0;
            fill_cnt    <= '0;
            len_q       <= LW'(MAX_DELAY_P);
        end else if (flush) begin
            valid_o  <= 1'b0;
            ptr      <= '0;
            fill_cnt <= '0;
        end else if (accept) begin
            valid_o     <= 1'b1;
            taps_o      <= taps_next;
            tap_valid_o <= tap_valid_next;
            primed_o    <= &tap_valid_next;
            ptr         <= ptr_next;
            fill_cnt    <= fill_next;
            if (fill_cnt == '0) begin
                len_q <= len_clamped;
            end
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multitap_line_buffer.sv
// Directed bench for multitap_line_buffer (WIDTH 8, MAX 12, TAPS 3) with a history-based model.
module tb_multitap_line_buffer;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush = 1'b0;
    logic [3:0]  len_i = 4'd4;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [7:0]  data_i = 8'h00;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [23:0] taps_o;
    logic [2:0]  tap_valid_o;
    logic        primed_o;

    int          total = 0;
    int          bad = 0;
    int          acc_cnt = 0;
    int          pop_cnt = 0;
    int          l_model = 12;
    logic [7:0]  hist[$];
    logic        acc;

    always #5 clk = ~clk;

    multitap_line_buffer #(.WIDTH_P(8), .MAX_DELAY_P(12), .NUM_TAPS_P(3)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
`ifdef MULTITAP_LINE_BUFFER_FLUSH_EN
        .flush_i     (flush),
`endif
        .len_i       (len_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .taps_o      (taps_o),
        .tap_valid_o (tap_valid_o),
        .primed_o    (primed_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, evaluate handshake, compare after the rising edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic r, output logic a);
        logic        pop;
        logic        p_v;
        logic [23:0] p_taps;
        logic [2:0]  p_tv;
        logic        p_pr;
        logic [23:0] e_taps;
        logic [2:0]  e_tv;
        int          n;
        @(negedge clk);
        valid_i = v;
        data_i  = d;
        ready_i = r;
        #1;
        a      = valid_i && ready_o && !rst_i;
        pop    = valid_o && ready_i && !rst_i && !flush;
        p_v    = valid_o;
        p_taps = taps_o;
        p_tv   = tap_valid_o;
        p_pr   = primed_o;
        if (!rst_i) check("ready_o", 32'(ready_o), 32'(flush ? 1'b0 : (!valid_o || ready_i)));
        @(posedge clk);
        #1;
        if (a) acc_cnt++;
        if (pop) pop_cnt++;
        if (rst_i) begin
            check("rst_valid", 32'(valid_o), 32'd0);
            check("rst_taps", 32'(taps_o), 32'd0);
            check("rst_tv", 32'(tap_valid_o), 32'd0);
            check("rst_primed", 32'(primed_o), 32'd0);
            hist.delete();
        end else if (flush) begin
            check("flush_valid", 32'(valid_o), 32'd0);
            hist.delete();
        end else if (a) begin
            n = hist.size();
            if (n == 0) l_model = (len_i == 0 || len_i > 12) ? 12 : int'(len_i);
            hist.push_back(d);
            e_taps = '0;
            e_tv   = '0;
            for (int k = 0; k < 3; k++) begin
                if (n >= k * l_model) begin
                    e_tv[k] = 1'b1;
                    e_taps[k*8 +: 8] = hist[n - k * l_model];
                end
            end
            check("acc_valid", 32'(valid_o), 32'd1);
            check("acc_taps", 32'(taps_o), 32'(e_taps));
            check("acc_tv", 32'(tap_valid_o), 32'(e_tv));
            check("acc_primed", 32'(primed_o), 32'(&e_tv));
        end else if (pop || !p_v) begin
            check("idle_valid", 32'(valid_o), 32'd0);
        end else begin
            check("stall_valid", 32'(valid_o), 32'd1);
            check("stall_taps", 32'(taps_o), 32'(p_taps));
            check("stall_tv", 32'(tap_valid_o), 32'(p_tv));
            check("stall_primed", 32'(primed_o), 32'(p_pr));
        end
    endtask

    task automatic do_reset();
        logic a;
        rst_i = 1'b1;
        cycle(1'b0, 8'h00, 1'b1, a);
        rst_i = 1'b0;
    endtask

    initial begin
        int         d;
        int         cyc;
        int         acc0;
        int         pop0;
        logic [3:0] pat;

        // Reset state, then a full-rate stream with L=4.
        len_i = 4'd4;
        do_reset();
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b1, 8'(i), 1'b1, acc);
            if (i == 5) begin
                check("b5_taps", 32'(taps_o), 32'h000105);
                check("b5_tv", 32'(tap_valid_o), 32'b011);
                check("b5_primed", 32'(primed_o), 32'd0);
            end
            if (i == 9) begin
                check("b9_taps", 32'(taps_o), 32'h010509);
                check("b9_tv", 32'(tap_valid_o), 32'b111);
                check("b9_primed", 32'(primed_o), 32'd1);
            end
            if (i == 20) check("b20_taps", 32'(taps_o), 32'h0C1014);
        end
        cycle(1'b0, 8'h00, 1'b1, acc);

        // Backpressure pattern 1,0,0,1 on ready_i.
        do_reset();
        pat = 4'b1001;
        d   = 1;
        cyc = 0;
        while (d <= 20 && cyc < 200) begin
            cycle(1'b1, 8'(d), pat[cyc % 4], acc);
            if (acc) d++;
            cyc++;
        end
        check("bp_all_accepted", 32'(d), 32'd21);
        cycle(1'b0, 8'h00, 1'b1, acc);

        // Random valid/ready; one output per accept.
        do_reset();
        acc0 = acc_cnt;
        pop0 = pop_cnt;
        for (int i = 0; i < 200; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), acc);
        end
        cycle(1'b0, 8'h00, 1'b1, acc);
        check("rand_beats", 32'(pop_cnt - pop0), 32'(acc_cnt - acc0));

        // len_i=0 clamps to 12; a later len_i change is ignored.
        len_i = 4'd0;
        do_reset();
        for (int i = 1; i <= 30; i++) begin
            if (i == 10) len_i = 4'd3;
            cycle(1'b1, 8'(i), 1'b1, acc);
            if (i == 24) check("len0_b24_primed", 32'(primed_o), 32'd0);
            if (i == 25) check("len0_b25_primed", 32'(primed_o), 32'd1);
            if (i == 30) check("len0_b30_taps", 32'(taps_o), 32'h06121E);
        end
        cycle(1'b0, 8'h00, 1'b1, acc);

        // Reset mid-stream after 7 beats.
        len_i = 4'd4;
        do_reset();
        for (int i = 1; i <= 7; i++) cycle(1'b1, 8'(i), 1'b1, acc);
        rst_i = 1'b1;
        cycle(1'b1, 8'h08, 1'b1, acc);
        rst_i = 1'b0;
        cycle(1'b1, 8'h09, 1'b1, acc);
        check("post_rst_tv", 32'(tap_valid_o), 32'b001);
        check("post_rst_taps", 32'(taps_o), 32'h000009);
        cycle(1'b0, 8'h00, 1'b1, acc);

`ifdef MULTITAP_LINE_BUFFER_FLUSH_EN
        // Flush after 10 beats, new length 2.
        do_reset();
        for (int i = 1; i <= 10; i++) cycle(1'b1, 8'(i), 1'b1, acc);
        flush = 1'b1;
        len_i = 4'd2;
        cycle(1'b1, 8'hAA, 1'b1, acc);
        check("flush_no_accept", 32'(acc), 32'd0);
        flush = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b1, 8'(8'h20 + i), 1'b1, acc);
            if (i == 1) check("flush_b1_tv", 32'(tap_valid_o), 32'b001);
            if (i == 4) check("flush_b4_primed", 32'(primed_o), 32'd0);
            if (i == 5) begin
                check("flush_b5_primed", 32'(primed_o), 32'd1);
                check("flush_b5_taps", 32'(taps_o), 32'h212325);
            end
        end
        cycle(1'b0, 8'h00, 1'b1, acc);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multitap_line_buffer.md
Name: multitap_line_buffer

Overview:
- Parametrised successor to the single-pair RAM delay buffer.
- Provides NUM_TAPS_P aligned taps per accepted sample: tap k is the sample accepted exactly k*L beats earlier.
- L is the line length, programmable at run time up to MAX_DELAY_P.
- Sits between pixel stream source and the Sobel 3x3 window: supplies vertically aligned pixels from consecutive image rows under full valid/ready backpressure.

Parameters:
- WIDTH_P, 8, bits per sample.
- MAX_DELAY_P, 640, maximum line length L (RAM depth per delay row).
- NUM_TAPS_P, 3, number of output taps, >= 2; uses NUM_TAPS_P-1 delay rows.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous active-high reset.
- len_i  in  $clog2(MAX_DELAY_P+1)  line length L; latched only when fill count is 0.
- valid_i  in  1  input sample valid.
- ready_o  out  1  block can accept.
- data_i  in  WIDTH_P  input sample.
- valid_o  out  1  output tap set valid.
- ready_i  in  1  downstream accepts.
- taps_o  out  NUM_TAPS_P*WIDTH_P  tap k in bits [k*WIDTH_P +: WIDTH_P]; tap 0 = current sample.
- tap_valid_o  out  NUM_TAPS_P  bit k set when tap k holds a real sample.
- primed_o  out  1  all taps real; fill count has reached (NUM_TAPS_P-1)*L.

Behaviour:
- Reset (synchronous, rst_i=1 at clk edge):
  - valid_o=0, taps_o=0, tap_valid_o=0, primed_o=0.
  - Write pointer=0, fill count=0, latched L=MAX_DELAY_P.
  - RAM contents are not cleared; unfilled taps are masked as described below.
- Accept: beat accepted when valid_i && ready_o.
- ready_o = !valid_o || ready_i (single output register, no bubble at full throughput).
- Latency: 1 cycle. taps_o/tap_valid_o/primed_o for a beat accepted at edge n are valid after edge n.
- Stall: while valid_o && !ready_i, taps_o, tap_valid_o and primed_o hold stable; pointer, fill count and RAM do not change.
- Length latch: L is captured from len_i on any accepted beat while fill count==0. len_i==0 or len_i>MAX_DELAY_P clamps to MAX_DELAY_P. len_i changes at other times are ignored until reset.
- Delay rows:
  - Write pointer wraps L-1 -> 0, advancing once per accepted beat.
  - Row r (1..NUM_TAPS_P-1) reads the oldest entry at the pointer and writes the row r-1 sample in its place, so each row adds exactly L beats of delay.
- Fill count:
  - Increments per accepted beat; saturates at (NUM_TAPS_P-1)*L.
  - tap_valid_o[k] = 1 iff the fill count before the accept is >= k*L. Bit 0 is always 1 on a valid output.
  - taps_o for tap k with tap_valid_o[k]=0 is forced to 0.
  - primed_o = &tap_valid_o.
- Every accepted beat produces exactly one output beat, including during priming; no samples are dropped or duplicated.
- Simultaneous accept and output pop in the same cycle is legal and sustains 1 beat/cycle.
- Reset mid-stream: an in-flight output is discarded (valid_o=0 next cycle); the next accepted beat starts a new fill.

Optional Feature:
- Macro: MULTITAP_LINE_BUFFER_FLUSH_EN.
- Defined: adds input port flush_i (1 bit).
  - flush_i=1 at an edge clears fill count, write pointer and valid_o, and re-enables the L latch; any beat presented that cycle is not accepted; ready_o=0 while flush_i=1.
  - Used at frame boundaries without a global reset.
- Undefined: no flush_i port; only rst_i restarts filling.

Test Plan:
- WIDTH 8, MAX 12, TAPS 3, len_i=4. Stream 0x01..0x14 with ready_i=1:
  - Beat 5 (0x05) -> taps {0,0x01,0x05}, tap_valid 3'b011.
  - Beat 9 (0x09) -> taps {0x01,0x05,0x09}, tap_valid 3'b111, primed_o=1.
  - Beat 20 (0x14) -> taps {0x0C,0x10,0x14}.
- Backpressure: toggle ready_i 1,0,0,1 during the same stream -> taps_o stable while stalled, ready_o=0 while full and stalled, no sample lost or duplicated (scoreboard vs reference model).
- Same stream with valid_i random 50% and ready_i random 50% -> every tap matches a model delay of k*4 accepted beats; 1 output beat per accept.
- len_i=0 at start -> L=12; first primed_o on accepted beat 25. Change len_i to 3 mid-stream -> no effect on delay.
- Assert rst_i for 1 cycle mid-stream after 7 beats -> valid_o=0, primed_o=0 next cycle; next beat yields tap_valid 3'b001.
- With MULTITAP_LINE_BUFFER_FLUSH_EN: flush_i pulse after 10 beats, new len_i=2 -> next beat has tap_valid 3'b001; 5th beat after flush gives primed_o=1.
